// File: rtl/y86_pkg.sv
// Shared Y86-64 types: status codes, register ids and the 64-bit word.
package y86_pkg;

  typedef enum logic [2:0] {
    SBUB = 3'd0,
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_t;

  typedef logic [3:0]  reg_id_t;
  typedef logic [63:0] word_t;

  localparam reg_id_t RNONE = 4'hF;
  localparam reg_id_t RRSP  = 4'h4;

  // Codes 5..7 have no meaning in the pipeline and are reported as SINS.
  function automatic stat_t fault_code(input logic [2:0] s);
    return (s > 3'd4) ? SINS : stat_t'(s);
  endfunction

endpackage

// File: rtl/regfile_core.sv
// 15x64 register array, dual write (M port wins), two zero-latency read ports.
// Write visible next cycle; same-cycle forwarding only when WB_BYPASS_EN is defined.
import y86_pkg::*;

module regfile_core #(
  parameter logic [63:0] STACK_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] rval_a,
  output logic [63:0] rval_b
);

  word_t regs_q [15];
  word_t regs_d [15];

  always_comb begin
    for (int i = 0; i < 15; i++) begin
      regs_d[i] = regs_q[i];
      if (we && dst_e == reg_id_t'(i)) regs_d[i] = val_e;
      // M port is applied last so it wins on a shared destination (popq %rsp).
      if (we && dst_m == reg_id_t'(i)) regs_d[i] = val_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (reg_id_t'(i) == RRSP) ? STACK_INIT : '0;
      end
    end else begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  function automatic word_t read_port(input reg_id_t src);
    word_t v;
    v = '0;
    if (src != RNONE) begin
`ifdef WB_BYPASS_EN
      if (we && src == dst_m)      v = val_m;
      else if (we && src == dst_e) v = val_e;
      else                         v = regs_q[src];
`else
      v = regs_q[src];
`endif
    end
    return v;
  endfunction

  always_comb begin
    rval_a = read_port(src_a);
    rval_b = read_port(src_b);
  end

endmodule

// File: rtl/wb_regfile.sv
// PIPE write-back: commit qualification, sticky status, retire counter around regfile_core.
// Writes land one edge after presentation; WB_BYPASS_EN adds same-cycle read forwarding.
import y86_pkg::*;

module wb_regfile #(
  parameter int          CNT_W      = 32,
  parameter logic [63:0] STACK_INIT = 64'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       w_stat,
  input  logic [3:0]       w_icode,
  input  logic [63:0]      w_valE,
  input  logic [63:0]      w_valM,
  input  logic [3:0]       w_dstE,
  input  logic [3:0]       w_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  output logic [2:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  stat_t            stat_q, stat_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             commit;
  logic             icode_unused;

  assign icode_unused = ^w_icode;

  // A faulting instruction never writes, and nothing writes once halted.
  assign commit = (stat_q == SAOK) && (w_stat == SAOK || w_stat == SBUB);

  always_comb begin
    stat_d    = stat_q;
    retired_d = retired_q;
    if (stat_q == SAOK) begin
      if (w_stat != SBUB) retired_d = retired_q + CNT_W'(1);
      if (w_stat != SAOK && w_stat != SBUB) stat_d = fault_code(w_stat);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q    <= SAOK;
      retired_q <= '0;
    end else begin
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  assign cpu_stat = stat_q;
  assign halted   = (stat_q != SAOK);
  assign retired  = retired_q;

  regfile_core #(
    .STACK_INIT(STACK_INIT)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit),
    .dst_e (w_dstE),
    .val_e (w_valE),
    .dst_m (w_dstM),
    .val_m (w_valM),
    .src_a (d_srcA),
    .src_b (d_srcB),
    .rval_a(d_rvalA),
    .rval_b(d_rvalB)
  );

endmodule
